fetch_redirect_unit: RTL and testbench
======================================

// Module: fetch_redirect_unit
// PURPOSE
//  Fetch-stage next-PC generator that consumes the branch predictor's outputs.
//  Drives the fetch PC and presents each predecoded branch to the predictor.
//  Applies taken predictions one cycle later and squashes the wrong-path fetch.
//  Tracks in-flight predictions in an in-order queue; compares them with ID-stage resolution and redirects/flushes on mispredict.
// PARAMETERS
//  XLEN      32     address width (= `N)
//  RESET_PC  32'h0  fetch PC after reset
//  PQ_DEPTH  4      prediction-queue entries (power of 2, >=2)
// PORTS
//  clk                  in   1     clock
//  rst_n                in   1     synchronous, active-low reset
//  i_stall              in   1     downstream stall: hold sequential PC advance
//  i_fetch_is_branch    in   1     predecode: instruction at o_pc is a branch (same cycle)
//  i_bpu_prediction     in   1     predictor taken/not-taken, valid 1 cycle after o_bpu_is_branch
//  i_bpu_predicted_pc   in   XLEN  predictor target (meaningful only when i_bpu_prediction=1)
//  i_resolve_valid      in   1     ID resolved oldest in-flight branch
//  i_resolve_taken      in   1     actual direction
//  i_resolve_target     in   XLEN  actual taken target
//  o_pc                 out  XLEN  current fetch PC
//  o_bpu_is_branch      out  1     present o_pc to predictor as branch
//  o_bpu_branch_pc      out  XLEN  = o_pc
//  o_squash             out  1     instruction fetched last cycle is wrong-path, drop it
//  o_flush              out  1     1-cycle mispredict flush of IF/ID
//  o_pq_full            out  1     queue (incl. pending entry) full; fetch held
// BEHAVIOUR
//  Reset: o_pc=RESET_PC; pending, queue count, all outputs 0.
//  Next-PC priority (all write PC even under i_stall):
//   1 mispredict -> PC <= taken ? i_resolve_target : head.pc+4
//   2 pending & i_bpu_prediction -> PC <= i_bpu_predicted_pc
//   3 ~i_stall & ~o_pq_full -> PC <= PC+4 (mod 2^XLEN)
//   4 else hold.
//  o_bpu_is_branch = i_fetch_is_branch & ~i_stall & ~o_pq_full & ~pending_taken & ~mispredict.
//  Cycle t: o_bpu_is_branch=1 -> pending<=1, pend_pc<=o_pc.
//  Cycle t+1: prediction consumed unconditionally (predictor does not hold).
//   Push {pend_pc, pred, pred ? target : pend_pc+4}; clear pending.
//   If pred=1: o_squash=1 (PC+4 fetch dropped).
//   A new branch may be sent at t+1 only if pred=0.
//  o_pq_full = (count + pending) == PQ_DEPTH; fetch holds PC and sends no branch.
//  Resolve (i_resolve_valid & count>0) pops head:
//   mispredict = taken != head.pred, or taken & target != head.target.
//  i_resolve_valid with empty queue: ignored, no state change.
//  Mispredict: o_flush=1 one cycle; queue count<=0, pending<=0; same-cycle push discarded.
//   o_squash is not asserted that cycle.
//  Push & pop same cycle (no mispredict): count unchanged, FIFO order kept.
//  Reset mid-operation: all entries dropped, PC=RESET_PC next cycle.
// CONFIGURATION
//  FRU_STATS_EN defined:
//   adds o_branch_cnt and o_mispred_cnt (out, 32 bit each).
//   Counters are saturating; increment on push / on mispredict; reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset, no branches, no stall, 4 cycles -> o_pc 0,4,8,C; o_squash/o_flush 0.
//  2 Branch at 0x10, pred taken to 0x80:
//    -> cycle t+1 o_squash=1; next o_pc=0x80; queue count 1.
//  3 Head {0x10,T,0x80}, resolve taken target 0x80 -> pop, no flush.
//    Resolve not-taken -> o_flush=1, o_pc=0x14, count 0.
//  4 PQ_DEPTH branches predicted not-taken, no resolve
//    -> o_pq_full=1, o_pc held, o_bpu_is_branch=0.
//    One resolve -> o_pq_full drops next cycle.
//  5 i_stall=1 during prediction cycle with pred taken to 0x40
//    -> o_pc=0x40 next cycle despite stall; entry pushed.
//  6 Mispredict same cycle as push -> push dropped, count 0, o_pc=correct target.
//    With FRU_STATS_EN: o_mispred_cnt=1.

Source files
------------

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-side bus of fetch_redirect_unit: stall, predecode, predictor and ID-resolution
// inputs plus the fetch PC, predictor request and squash/flush/full outputs.
interface fetch_redirect_unit_if #(
   parameter int XLEN = 32
);
   logic            i_stall;
   logic            i_fetch_is_branch;
   logic            i_bpu_prediction;
   logic [XLEN-1:0] i_bpu_predicted_pc;
   logic            i_resolve_valid;
   logic            i_resolve_taken;
   logic [XLEN-1:0] i_resolve_target;
   logic [XLEN-1:0] o_pc;
   logic            o_bpu_is_branch;
   logic [XLEN-1:0] o_bpu_branch_pc;
   logic            o_squash;
   logic            o_flush;
   logic            o_pq_full;

   modport master (
      input  i_stall, i_fetch_is_branch, i_bpu_prediction, i_bpu_predicted_pc,
             i_resolve_valid, i_resolve_taken, i_resolve_target,
      output o_pc, o_bpu_is_branch, o_bpu_branch_pc, o_squash, o_flush, o_pq_full
   );

   modport slave (
      output i_stall, i_fetch_is_branch, i_bpu_prediction, i_bpu_predicted_pc,
             i_resolve_valid, i_resolve_taken, i_resolve_target,
      input  o_pc, o_bpu_is_branch, o_bpu_branch_pc, o_squash, o_flush, o_pq_full
   );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch next-PC generator with one-cycle-late taken redirects and an in-order prediction queue.
// Optional FRU_STATS_EN adds saturating branch/mispredict counters (o_branch_cnt, o_mispred_cnt).
module fetch_redirect_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PQ_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fetch_redirect_unit_if.master bus
`ifdef FRU_STATS_EN
   ,
   output logic [31:0]           o_branch_cnt,
   output logic [31:0]           o_mispred_cnt
`endif
);
   localparam int PTR_W = $clog2(PQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             pend_q;
   logic [XLEN-1:0]  pend_pc_q;
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   logic [XLEN-1:0]  pq_pc   [PQ_DEPTH];
   logic             pq_pred [PQ_DEPTH];
   logic [XLEN-1:0]  pq_tgt  [PQ_DEPTH];

   logic             pq_full, pend_taken, resolve, mispredict, issue, push, pop;
   logic [XLEN-1:0]  head_pc, head_tgt, push_tgt;
   logic             head_pred;

   // The pending (not yet pushed) prediction reserves a queue slot.
   assign pq_full    = (count_q + CNT_W'(pend_q)) == CNT_W'(PQ_DEPTH);
   assign pend_taken = pend_q & bus.i_bpu_prediction;
   assign resolve    = bus.i_resolve_valid & (count_q != '0);

   assign head_pc    = pq_pc[head_q];
   assign head_pred  = pq_pred[head_q];
   assign head_tgt   = pq_tgt[head_q];

   assign mispredict = resolve & ((bus.i_resolve_taken != head_pred) |
                                  (bus.i_resolve_taken & (bus.i_resolve_target != head_tgt)));

   assign issue    = bus.i_fetch_is_branch & ~bus.i_stall & ~pq_full & ~pend_taken & ~mispredict;
   assign push     = pend_q & ~mispredict;
   assign pop      = resolve & ~mispredict;
   assign push_tgt = bus.i_bpu_prediction ? bus.i_bpu_predicted_pc : pend_pc_q + XLEN'(4);

   always_comb begin
      pc_d = pc_q;
      if (mispredict) begin
         pc_d = bus.i_resolve_taken ? bus.i_resolve_target : head_pc + XLEN'(4);
      end else if (pend_taken) begin
         pc_d = bus.i_bpu_predicted_pc;
      end else if (~bus.i_stall & ~pq_full) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         pc_q   <= pc_d;
         pend_q <= issue;
         if (issue) begin
            pend_pc_q <= pc_q;
         end
         if (mispredict) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Entry storage carries no reset; validity lives entirely in the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         pq_pc[tail_q]   <= pend_pc_q;
         pq_pred[tail_q] <= bus.i_bpu_prediction;
         pq_tgt[tail_q]  <= push_tgt;
      end
   end

   assign bus.o_pc            = pc_q;
   assign bus.o_bpu_is_branch = issue;
   assign bus.o_bpu_branch_pc = pc_q;
   assign bus.o_squash        = pend_taken & ~mispredict;
   assign bus.o_flush         = mispredict;
   assign bus.o_pq_full       = pq_full;

`ifdef FRU_STATS_EN
   logic [31:0] branch_cnt_q, mispred_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (push && (branch_cnt_q != '1))        branch_cnt_q  <= branch_cnt_q + 32'd1;
         if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign o_branch_cnt  = branch_cnt_q;
   assign o_mispred_cnt = mispred_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomized bench for fetch_redirect_unit against a queue-based reference of the redirect rules.
module tb_fetch_redirect_unit;
   localparam int          XLEN   = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_redirect_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FRU_STATS_EN
   logic [31:0] branch_cnt, mispred_cnt;
`endif

   fetch_redirect_unit #(
      .XLEN(XLEN), .RESET_PC(RST_PC), .PQ_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef FRU_STATS_EN
      ,
      .o_branch_cnt(branch_cnt),
      .o_mispred_cnt(mispred_cnt)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      bit          pred;
      logic [31:0] tgt;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_pend_pc;
   int          m_br_cnt, m_mis_cnt;
   int          checks = 0;
   int          errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc      = RST_PC;
      m_pend    = 0;
      m_pend_pc = '0;
      mq.delete();
      m_br_cnt  = 0;
      m_mis_cnt = 0;
   endtask

   // One clock: drive random inputs after the edge, check outputs, then advance the model.
   task automatic do_cycle(input bit rst, input int br_pct, input int st_pct,
                           input int rv_pct, input int ok_pct);
      bit          full, ptaken, mis, is_br, has_head;
      ent_t        head;
      logic [31:0] npc;
      @(posedge clk);
      #1;
      rst_n                  = !rst;
      bus.i_fetch_is_branch  = ($urandom_range(99) < br_pct);
      bus.i_stall            = ($urandom_range(99) < st_pct);
      bus.i_bpu_prediction   = $urandom_range(1);
      bus.i_bpu_predicted_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      bus.i_resolve_valid    = ($urandom_range(99) < rv_pct);
      if (mq.size() > 0 && $urandom_range(99) < ok_pct) begin
         bus.i_resolve_taken  = mq[0].pred;
         bus.i_resolve_target = mq[0].pred ? mq[0].tgt : ($urandom & 32'hFFFF_FFFC);
      end else begin
         bus.i_resolve_taken  = $urandom_range(1);
         bus.i_resolve_target = $urandom & 32'hFFFF_FFFC;
      end
      #1;
      if (rst) begin
         model_reset();
         return;
      end

      has_head = (mq.size() > 0);
      if (has_head) head = mq[0];
      full   = (mq.size() + int'(m_pend)) == DEPTH;
      ptaken = m_pend && bus.i_bpu_prediction;
      mis    = bus.i_resolve_valid && has_head &&
               ((bus.i_resolve_taken != head.pred) ||
                (bus.i_resolve_taken && bus.i_resolve_target != head.tgt));
      is_br  = bus.i_fetch_is_branch && !bus.i_stall && !full && !ptaken && !mis;

      check_val("pc",        bus.o_pc, m_pc);
      check_val("branch_pc", bus.o_bpu_branch_pc, m_pc);
      check_val("is_branch", 32'(bus.o_bpu_is_branch), 32'(is_br));
      check_val("squash",    32'(bus.o_squash), 32'(ptaken && !mis));
      check_val("flush",     32'(bus.o_flush), 32'(mis));
      check_val("pq_full",   32'(bus.o_pq_full), 32'(full));
`ifdef FRU_STATS_EN
      check_val("branch_cnt",  branch_cnt, 32'(m_br_cnt));
      check_val("mispred_cnt", mispred_cnt, 32'(m_mis_cnt));
`endif

      if (bus.i_resolve_valid && has_head)
         $display("resolve pc=%h pred=%0d taken=%0d target=%h -> %s", head.pc, head.pred,
                  bus.i_resolve_taken, bus.i_resolve_target, mis ? "redirect" : "retire");

      if (mis) begin
         npc = bus.i_resolve_taken ? bus.i_resolve_target : head.pc + 32'd4;
         mq.delete();
         m_pend = 0;
         m_mis_cnt++;
      end else begin
         if (bus.i_resolve_valid && has_head) void'(mq.pop_front());
         if (m_pend) begin
            ent_t e;
            e.pc   = m_pend_pc;
            e.pred = bus.i_bpu_prediction;
            e.tgt  = e.pred ? bus.i_bpu_predicted_pc : m_pend_pc + 32'd4;
            mq.push_back(e);
            m_br_cnt++;
         end
         if (ptaken)                     npc = bus.i_bpu_predicted_pc;
         else if (!bus.i_stall && !full) npc = m_pc + 32'd4;
         else                            npc = m_pc;
         m_pend = is_br;
         if (is_br) m_pend_pc = m_pc;
      end
      m_pc = npc;
   endtask

   initial begin
      bus.i_stall            = 1'b0;
      bus.i_fetch_is_branch  = 1'b0;
      bus.i_bpu_prediction   = 1'b0;
      bus.i_bpu_predicted_pc = '0;
      bus.i_resolve_valid    = 1'b0;
      bus.i_resolve_taken    = 1'b0;
      bus.i_resolve_target   = '0;
      model_reset();

      repeat (3) do_cycle(1, 0, 0, 0, 0);
      // Idle fetch after reset walks 0,4,8,C.
      repeat (4) do_cycle(0, 0, 0, 0, 0);
      // Rare resolves: the queue fills and fetch must hold.
      repeat (800) do_cycle(0, 60, 20, 8, 85);
      // Reset in the middle of traffic.
      repeat (2) do_cycle(1, 50, 20, 30, 50);
      repeat (1200) do_cycle(0, 45, 25, 40, 60);
      repeat (500) do_cycle(0, 70, 5, 60, 90);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
